// File: rtl/chained_bram_fifo_pkg.sv
// Shared constants for the chained BRAM FIFO: iCE40 tile geometry and lane sizing.
package chained_bram_fifo_pkg;

  localparam int TILE_WORDS     = 256;
  localparam int TILE_ADDR_BITS = 8;
  localparam int TILE_DATA_BITS = 16;

  // Number of parallel 16-bit tiles needed to hold one payload word.
  function automatic int lane_count(input int data_width);
    return (data_width + TILE_DATA_BITS - 1) / TILE_DATA_BITS;
  endfunction

endpackage

// File: rtl/chained_bram_fifo_if.sv
// Ready/valid producer and consumer bundle of the chained BRAM FIFO, plus status.
interface chained_bram_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 11
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;

  // FIFO side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, full, empty, almost_full
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, full, empty, almost_full
  );
endinterface

// File: rtl/chained_bram_fifo_bank.sv
// LANES x BRAM_COUNT tile array addressed as one deep memory. The upper address
// bits pick a tile column; the read-side tile index is registered with the read
// so the output mux never depends on an unregistered address.
module chained_bram_bank
  import chained_bram_fifo_pkg::*;
#(
  parameter  int LANES      = 1,
  parameter  int BRAM_COUNT = 4,
  parameter  int TILE_W     = 2,
  localparam int ADDR_W     = TILE_ADDR_BITS + TILE_W,
  localparam int LW         = LANES * TILE_DATA_BITS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [LW-1:0]     wdata_i,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [LW-1:0]     rdata_o
);
  logic [TILE_W-1:0]         wtile_s;
  logic [TILE_W-1:0]         rtile_s;
  logic [TILE_W-1:0]         rtile_q;
  logic [TILE_DATA_BITS-1:0] tile_rdata_s [BRAM_COUNT][LANES];

  assign wtile_s = waddr_i[ADDR_W-1:TILE_ADDR_BITS];
  assign rtile_s = raddr_i[ADDR_W-1:TILE_ADDR_BITS];

  for (genvar t = 0; t < BRAM_COUNT; t++) begin : g_tile
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      ice40_bram u_bram (
        .clk_i   (clk_i),
        .wen_i   (wen_i && (wtile_s == TILE_W'(t))),
        .waddr_i (waddr_i[TILE_ADDR_BITS-1:0]),
        .wdata_i (wdata_i[l*TILE_DATA_BITS +: TILE_DATA_BITS]),
        .ren_i   (ren_i && (rtile_s == TILE_W'(t))),
        .raddr_i (raddr_i[TILE_ADDR_BITS-1:0]),
        .rdata_o (tile_rdata_s[t][l])
      );
    end
  end

  // Remember which tile column answers the read issued this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rtile_q <= {TILE_W{1'b0}};
    end else if (ren_i) begin
      rtile_q <= rtile_s;
    end
  end

  // AND-OR select of the answering tile column, lane by lane.
  always_comb begin
    rdata_o = {LW{1'b0}};
    for (int t = 0; t < BRAM_COUNT; t++) begin
      for (int l = 0; l < LANES; l++) begin
        rdata_o[l*TILE_DATA_BITS +: TILE_DATA_BITS] =
          rdata_o[l*TILE_DATA_BITS +: TILE_DATA_BITS] |
          (tile_rdata_s[t][l] & {TILE_DATA_BITS{rtile_q == TILE_W'(t)}});
      end
    end
  end
endmodule

// File: rtl/ice40_bram.sv
// Behavioural iCE40 256x16 block RAM: synchronous write, registered read.
module ice40_bram
  import chained_bram_fifo_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      wen_i,
  input  logic [TILE_ADDR_BITS-1:0] waddr_i,
  input  logic [TILE_DATA_BITS-1:0] wdata_i,
  input  logic                      ren_i,
  input  logic [TILE_ADDR_BITS-1:0] raddr_i,
  output logic [TILE_DATA_BITS-1:0] rdata_o
);
  logic [TILE_DATA_BITS-1:0] mem_q [TILE_WORDS];
  logic [TILE_DATA_BITS-1:0] rdata_q;

  // Storage array write port; contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk_i) begin
    if (ren_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/chained_bram_fifo.sv
// First-word-fall-through FIFO over chained BRAM tiles. Words sit in the bank
// until a prefetch read pulls them into a 2-entry output stage (head + skid),
// which keeps one read in flight and streams one word per cycle.
module chained_bram_fifo
  import chained_bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int BRAM_COUNT  = 4,
  parameter int LANES       = lane_count(DATA_WIDTH),
  parameter int DEPTH       = TILE_WORDS * BRAM_COUNT,
  parameter int AFULL_LEVEL = DEPTH - 16
) (
  input logic                clk,
  input logic                rst,
  input logic                clear,
  chained_bram_fifo_if.slave bus
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TILE_W = (BRAM_COUNT > 1) ? $clog2(BRAM_COUNT) : 1;
  localparam int ADDR_W = TILE_ADDR_BITS + TILE_W;
  localparam int LW     = LANES * TILE_DATA_BITS;

  logic [ADDR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      mem_count_q, mem_count_d, count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            stage_count_q, stage_count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic                  push_s, pop_s, issue_s, flush_s;
  logic [LW-1:0]         wdata_s, rdata_s;
  logic [DATA_WIDTH-1:0] rword_s;
  logic                  unused_rdata_s;

  assign flush_s = rst || clear;
  assign push_s  = bus.in_valid && bus.in_ready;
  assign pop_s   = bus.out_valid && bus.out_ready;
  // Read only what was already in memory before this edge, and only while
  // the stage plus the in-flight word (after this pop) leaves room.
  assign issue_s = (mem_count_q != {CNT_W{1'b0}}) &&
                   ((3'(stage_count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop_s)));

  assign wdata_s        = LW'(bus.in_data);
  assign rword_s        = rdata_s[DATA_WIDTH-1:0];
  assign unused_rdata_s = ^rdata_s;

  chained_bram_bank #(
    .LANES      (LANES),
    .BRAM_COUNT (BRAM_COUNT),
    .TILE_W     (TILE_W)
  ) u_bank (
    .clk_i   (clk),
    .rst_i   (flush_s),
    .wen_i   (push_s && !flush_s),
    .waddr_i (wptr_q),
    .wdata_i (wdata_s),
    .ren_i   (issue_s && !flush_s),
    .raddr_i (rptr_q),
    .rdata_o (rdata_s)
  );

  // Next-state for pointers, occupancy counters and the output stage.
  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    mem_count_d   = mem_count_q;
    count_d       = count_q;
    inflight_d    = issue_s;
    head_d        = head_q;
    skid_d        = skid_q;
    stage_count_d = stage_count_q;

    if (push_s) begin
      wptr_d = (wptr_q == ADDR_W'(DEPTH - 1)) ? {ADDR_W{1'b0}} : wptr_q + ADDR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (issue_s) begin
      rptr_d = (rptr_q == ADDR_W'(DEPTH - 1)) ? {ADDR_W{1'b0}} : rptr_q + ADDR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_s, issue_s})
      2'b10:   mem_count_d = mem_count_q + CNT_W'(1);
      2'b01:   mem_count_d = mem_count_q - CNT_W'(1);
      default: mem_count_d = mem_count_q;
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case ({pop_s, inflight_q})
      2'b01: begin
        if (stage_count_q == 2'd0) begin
          head_d = rword_s;
        end else begin
          skid_d = rword_s;
        end
        stage_count_d = stage_count_q + 2'd1;
      end
      2'b10: begin
        head_d        = skid_q;
        stage_count_d = stage_count_q - 2'd1;
      end
      2'b11: begin
        if (stage_count_q == 2'd1) begin
          head_d = rword_s;
        end else begin
          head_d = skid_q;
          skid_d = rword_s;
        end
      end
      default: stage_count_d = stage_count_q;
    endcase
  end

  // State register; rst and clear both flush and win over any push/pop.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      wptr_q        <= {ADDR_W{1'b0}};
      rptr_q        <= {ADDR_W{1'b0}};
      mem_count_q   <= {CNT_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      inflight_q    <= 1'b0;
      stage_count_q <= 2'd0;
      head_q        <= {DATA_WIDTH{1'b0}};
      skid_q        <= {DATA_WIDTH{1'b0}};
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mem_count_q   <= mem_count_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      stage_count_q <= stage_count_d;
      head_q        <= head_d;
      skid_q        <= skid_d;
    end
  end

  assign bus.in_ready    = (count_q < CNT_W'(DEPTH));
  assign bus.out_valid   = (stage_count_q != 2'd0);
  assign bus.out_data    = head_q;
  assign bus.count       = count_q;
  assign bus.full        = (count_q == CNT_W'(DEPTH));
  assign bus.empty       = (count_q == {CNT_W{1'b0}});
  assign bus.almost_full = (count_q >= CNT_W'(AFULL_LEVEL));
endmodule

// File: tb/tb_chained_bram_fifo.sv
// Bench for chained_bram_fifo (24-bit payload, two tiles deep): directed
// scenarios with literal expectations plus a queue-based reference model.
module tb_chained_bram_fifo;
  localparam int DW    = 24;
  localparam int BC    = 2;
  localparam int DEPTH = 512;
  localparam int AFULL = DEPTH - 16;
  localparam int CW    = 10;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  chained_bram_fifo_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

  chained_bram_fifo #(.DATA_WIDTH(DW), .BRAM_COUNT(BC)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  // Reference: an ordered queue; each word becomes visible two edges after its push.
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;

  ent_t mq[$];
  int   cyc        = 0;
  int   pops_total = 0;
  bit   started    = 1'b0;
  int   n_vec      = 0;
  int   n_miss     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model update at each active edge.
  always @(posedge clk) begin : model
    bit   mv;
    bit   can_push;
    ent_t e;
    mv       = (mq.size() > 0) && ((cyc - mq[0].t) >= 2);
    can_push = (mq.size() < DEPTH);
    cyc++;
    if (rst || clear) begin
      mq.delete();
    end else begin
      if (mv && bus.out_ready) begin
        void'(mq.pop_front());
        pops_total++;
      end
      if (bus.in_valid && can_push) begin
        e.d = bus.in_data;
        e.t = cyc;
        mq.push_back(e);
      end
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin : cmp
    int n;
    bit ev;
    if (started) begin
      n  = mq.size();
      ev = (n > 0) && ((cyc - mq[0].t) >= 2);
      check("count",       32'(bus.count),       32'(n));
      check("empty",       32'(bus.empty),       32'(n == 0));
      check("full",        32'(bus.full),        32'(n == DEPTH));
      check("almost_full", 32'(bus.almost_full), 32'(n >= AFULL));
      check("in_ready",    32'(bus.in_ready),    32'(n < DEPTH));
      check("out_valid",   32'(bus.out_valid),   32'(ev));
      if (ev && bus.out_valid) begin
        check("out_data", 32'(bus.out_data), 32'(mq[0].d));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the stimulus below is bounded, this only guards a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  k;
    int  pops0;
    bit  saw_full;
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 24'd0;
    bus.out_ready = 1'b0;
    step();
    started = 1'b1;
    step();
    check("rst_out_valid", 32'(bus.out_valid),   32'd0);
    check("rst_out_data",  32'(bus.out_data),    32'd0);
    check("rst_count",     32'(bus.count),       32'd0);
    check("rst_empty",     32'(bus.empty),       32'd1);
    check("rst_full",      32'(bus.full),        32'd0);
    check("rst_afull",     32'(bus.almost_full), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),    32'd1);
    rst = 1'b0;

    // 1: single word latency
    bus.in_data  = 24'h00A5A5;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("t1_valid_e0", 32'(bus.out_valid), 32'd0);
    step();
    check("t1_valid_e1", 32'(bus.out_valid), 32'd0);
    step();
    check("t1_valid_e2", 32'(bus.out_valid), 32'd1);
    check("t1_data",     32'(bus.out_data),  32'h0000A5A5);
    check("t1_count",    32'(bus.count),     32'd1);
    check("t1_empty",    32'(bus.empty),     32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t1_popped", 32'(bus.count), 32'd0);

    // 2: fill to full, overflow push ignored
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_data  = DW'(i);
      bus.in_valid = 1'b1;
      step();
      if (i == AFULL - 2) check("t2_afull_495", 32'(bus.almost_full), 32'd0);
      if (i == AFULL - 1) check("t2_afull_496", 32'(bus.almost_full), 32'd1);
    end
    check("t2_count",    32'(bus.count),    32'd512);
    check("t2_full",     32'(bus.full),     32'd1);
    check("t2_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data = 24'd999;
    step();
    bus.in_valid = 1'b0;
    check("t2_overflow", 32'(bus.count), 32'd512);
    step();
    check("t2_head", 32'(bus.out_data), 32'd0);

    // 3: drain at one word per cycle
    bus.out_ready = 1'b1;
    k = 0;
    while (bus.count != '0 && k < 600) begin
      step();
      k++;
    end
    check("t3_drain_cycles", 32'(k),         32'd512);
    check("t3_empty",        32'(bus.empty), 32'd1);

    // 4: continuous streaming across tile boundary and pointer wrap
    pops0 = pops_total;
    for (int i = 0; i < 1500; i++) begin
      bus.in_data  = DW'(32'h1000 + i);
      bus.in_valid = 1'b1;
      step();
    end
    check("t4_level", 32'(bus.count), 32'd3);
    bus.in_valid = 1'b0;
    repeat (3) step();
    check("t4_pops",  32'(pops_total - pops0), 32'd1500);
    check("t4_count", 32'(bus.count),          32'd0);

    // 5: randomized traffic in four phases
    void'($urandom(32'd20240611));
    saw_full = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = DW'($urandom);
      case (c / 2500)
        0:       bus.out_ready = ($urandom_range(0, 3) == 0);
        1:       bus.out_ready = ($urandom_range(0, 1) == 0);
        2:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = ($urandom_range(0, 1) == 0);
      endcase
      step();
      if (bus.full) saw_full = 1'b1;
    end
    check("t5_reached_full", 32'(saw_full), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (bus.count != '0 && k < 600) begin
      step();
      k++;
    end
    check("t5_drained", 32'(bus.count), 32'd0);

    // 6: clear with a same-cycle push, then a full-width word
    bus.out_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.in_data  = DW'(32'h500 + i);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    check("t6_held", 32'(bus.count), 32'd100);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h123456;
    step();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("t6_clr_count", 32'(bus.count),     32'd0);
    check("t6_clr_valid", 32'(bus.out_valid), 32'd0);
    check("t6_clr_empty", 32'(bus.empty),     32'd1);
    repeat (3) step();
    check("t6_no_ghost", 32'(bus.out_valid), 32'd0);
    bus.in_data  = 24'hABCDEF;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check("t6_w24_valid", 32'(bus.out_valid), 32'd1);
    check("t6_w24_data",  32'(bus.out_data),  32'h00ABCDEF);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t6_final_empty", 32'(bus.empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
